cosine_sequencer: RTL and testbench

- FSM controller for the cosine/distance datapath.
- Accepts a request from the sensor front end, drives the datapath's 3-bit state code through StandBy, Alert, StartCalculation, AccumulateTerms and CalculateDistance, and counts series terms.
- Waits for the datapath's done flag under a timeout, then holds a result-valid handshake until the consumer acknowledges.

---
 rtl/cosine_sequencer.sv | 114 +++++++++++
 tb/tb_cosine_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cosine_sequencer.sv
// Sequencer for the cosine/distance datapath: request handshake, series-term
// counting, done-wait with timeout, and a held result-valid handshake.
module cosine_sequencer #(
  parameter int NTERMS  = 6,
  parameter int TERM_W  = 3,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              asyncclear_n,
  input  logic              req,
  output logic              ack,
  input  logic              abort,
  input  logic              dp_done,
  output logic [2:0]        state,
  output logic [TERM_W-1:0] term_idx,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ack,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    StandBy           = 3'd0,
    Alert             = 3'd1,
    StartCalculation  = 3'd2,
    AccumulateTerms   = 3'd3,
    CalculateDistance = 3'd4,
    ResultHold        = 3'd5
  } seqState_e;

  localparam logic [TERM_W-1:0] LastTerm = TERM_W'(NTERMS - 1);
  localparam logic [TO_W-1:0]   LastWait = TO_W'(TIMEOUT - 1);

  seqState_e         curState_r;
  seqState_e         nextState_s;
  logic [TERM_W-1:0] termIdx_r;
  logic [TERM_W-1:0] termIdxNext_s;
  logic [TO_W-1:0]   toCnt_r;
  logic [TO_W-1:0]   toCntNext_s;
  logic              timeoutHit_s;

  // Next-state decode; abort overrides everything, including a pending timeout.
  always_comb begin
    nextState_s  = StandBy;
    timeoutHit_s = 1'b0;
    if (abort) begin
      nextState_s = StandBy;
    end else begin
      case (curState_r)
        StandBy:          nextState_s = req ? Alert : StandBy;
        Alert:            nextState_s = StartCalculation;
        StartCalculation: nextState_s = AccumulateTerms;
        AccumulateTerms: begin
          if (termIdx_r == LastTerm) nextState_s = CalculateDistance;
          else                       nextState_s = AccumulateTerms;
        end
        CalculateDistance: begin
          if (dp_done) begin
            nextState_s = ResultHold;
          end else if (toCnt_r == LastWait) begin
            nextState_s  = StandBy;
            timeoutHit_s = 1'b1;
          end else begin
            nextState_s = CalculateDistance;
          end
        end
        ResultHold:       nextState_s = result_ack ? StandBy : ResultHold;
        default:          nextState_s = StandBy;
      endcase
    end
  end

  // Counters advance only while staying in their own state, so they read 0 elsewhere.
  always_comb begin
    termIdxNext_s = '0;
    toCntNext_s   = '0;
    if ((curState_r == AccumulateTerms) && (nextState_s == AccumulateTerms)) begin
      termIdxNext_s = termIdx_r + TERM_W'(1);
    end else begin
      termIdxNext_s = '0;
    end
    if ((curState_r == CalculateDistance) && (nextState_s == CalculateDistance)) begin
      toCntNext_s = toCnt_r + TO_W'(1);
    end else begin
      toCntNext_s = '0;
    end
  end

  // State, counters and all outputs registered from the next-state decode.
  always_ff @(posedge clk or negedge asyncclear_n) begin
    if (!asyncclear_n) begin
      curState_r   <= StandBy;
      termIdx_r    <= '0;
      toCnt_r      <= '0;
      ack          <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      curState_r   <= nextState_s;
      termIdx_r    <= termIdxNext_s;
      toCnt_r      <= toCntNext_s;
      ack          <= (nextState_s == Alert);
      busy         <= (nextState_s != StandBy);
      result_valid <= (nextState_s == ResultHold);
      err_timeout  <= timeoutHit_s;
    end
  end

  assign state    = curState_r;
  assign term_idx = termIdx_r;

endmodule

// File: tb/tb_cosine_sequencer.sv
// Directed-vector bench for cosine_sequencer: stimulus queues per-cycle
// expectations, a monitor process pops and compares them after each edge.
module tb_cosine_sequencer;

  logic       clk = 1'b0;
  logic       asyncclear_n = 1'b0;
  logic       req = 1'b0;
  logic       abort = 1'b0;
  logic       dp_done = 1'b0;
  logic       result_ack = 1'b0;
  logic       ack;
  logic [2:0] state;
  logic [2:0] term_idx;
  logic       busy;
  logic       result_valid;
  logic       err_timeout;

  int nVec = 0;
  int nBad = 0;
  logic [7:0] expQ[$];

  cosine_sequencer #(.NTERMS(6), .TERM_W(3), .TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .asyncclear_n(asyncclear_n), .req(req), .ack(ack), .abort(abort),
    .dp_done(dp_done), .state(state), .term_idx(term_idx), .busy(busy),
    .result_valid(result_valid), .result_ack(result_ack), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Monitor: compares the outputs after every edge against the queued vector.
  initial begin
    logic [7:0] e;
    logic [9:0] want;
    logic [9:0] got;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() != 0) begin
        e    = expQ.pop_front();
        want = {e[7:5], e[4:2], e[1], (e[7:5] != 3'd0), (e[7:5] == 3'd5), e[0]};
        got  = {state, term_idx, ack, busy, result_valid, err_timeout};
        nVec++;
        if (got !== want) begin
          nBad++;
          $display("FAIL vec%0d st/idx/ack/busy/rv/err: got %0d/%0d/%b/%b/%b/%b want %0d/%0d/%b/%b/%b/%b",
                   nVec, got[9:7], got[6:4], got[3], got[2], got[1], got[0],
                   want[9:7], want[6:4], want[3], want[2], want[1], want[0]);
        end
      end
    end
  end

  // One clock: inputs held across the next edge, expected outputs after it.
  task automatic cyc(input logic r, input logic a, input logic d, input logic k,
                     input logic [2:0] s, input logic [2:0] ti,
                     input logic ak, input logic er);
    @(negedge clk);
    req = r; abort = a; dp_done = d; result_ack = k;
    expQ.push_back({s, ti, ak, er});
  endtask

  // Request through StartCalculation and all six terms, ending in CalculateDistance.
  task automatic runToCalc();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic checkNow(input string name, input logic [9:0] got, input logic [9:0] want);
    nVec++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  initial begin
    #1;
    checkNow("reset_outputs", {state, term_idx, ack, busy, result_valid, err_timeout}, 10'd0);
    @(negedge clk);
    asyncclear_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

    // Nominal: done on third CalculateDistance cycle, ack two cycles into ResultHold.
    runToCalc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

    // Timeout: fifteen CalculateDistance cycles, then one err pulse in StandBy.
    runToCalc();
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

    // dp_done on the expiring cycle wins over the timeout.
    runToCalc();
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);

    // Abort at term 3, then a fresh request runs normally.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    runToCalc();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);

    // Abort with req in StandBy stays put; result_ack outside ResultHold is ignored.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);

    // Back-to-back: req held high, immediate done and ack, one StandBy gap.
    runToCalc();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-AccumulateTerms, checked before any further edge.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'(i), 1'b0, 1'b0);
    @(negedge clk);
    checkNow("pre_reset_accum", {state, term_idx, ack, busy, result_valid, err_timeout},
             {3'd3, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0});
    #1 asyncclear_n = 1'b0;
    #1;
    checkNow("async_reset", {state, term_idx, ack, busy, result_valid, err_timeout}, 10'd0);
    @(negedge clk);
    asyncclear_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    nVec++;
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL drain: got %0d pending vectors want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
